expand_add_sched: RTL

Scheduler for the four-lane 12-bit float expand adder in the fire-module expand path. It takes two independent streams of 48-bit expand results (expand-1 and expand-2) and buffers each in a small FIFO. It pairs their words in order, issues each pair to the adder with a one-cycle add enable, and collects the sums after the fixed adder latency into a credit-protected output buffer with valid/ready backpressure. A per-layer word counter sequences start, drain and done.

---
 rtl/expand_add_sched.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/expand_add_sched.sv
// Pairs expand-1 / expand-2 words from two small FIFOs, issues them to the lane adder,
// and buffers the returning sums behind a credit counter so backpressure never drops data.
module expand_add_sched #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADD_LAT    = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] word_count_i,
    input  logic             bypass_i,
    input  logic [47:0]      e1_data_i,
    input  logic             e1_valid_i,
    output logic             e1_ready_o,
    input  logic [47:0]      e2_data_i,
    input  logic             e2_valid_i,
    output logic             e2_ready_o,
    output logic [47:0]      expand_1_o,
    output logic [47:0]      expand_2_o,
    output logic             add_en_o,
    input  logic [47:0]      sum_i,
    output logic [47:0]      out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             busy_o,
    output logic             done_o
);

    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int OUT_DEPTH = ADD_LAT + 2;
    localparam int OPTR_W    = $clog2(OUT_DEPTH);
    localparam int CRD_W     = $clog2(OUT_DEPTH + 1);

    localparam logic [PTR_W:0]     FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]     FCNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1);
    localparam logic [CRD_W-1:0]   CRD_MAX   = CRD_W'(OUT_DEPTH);
    localparam logic [CRD_W-1:0]   CRD_ONE   = CRD_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [OPTR_W-1:0]  OPTR_ONE  = OPTR_W'(1);
    localparam logic [OPTR_W-1:0]  OPTR_LAST = OPTR_W'(OUT_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic               bypass_q, bypass_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [CNT_W-1:0]   acc1_q, acc1_d;
    logic [CNT_W-1:0]   acc2_q, acc2_d;
    logic [CRD_W-1:0]   credits_q, credits_d;

    logic [47:0]        e1Mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   e1Wr_q, e1Rd_q;
    logic [PTR_W:0]     e1Cnt_q;
    logic [47:0]        e2Mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   e2Wr_q, e2Rd_q;
    logic [PTR_W:0]     e2Cnt_q;

    logic [47:0]        expand1_q, expand2_q;
    logic               addEn_q;
    logic [ADD_LAT-1:0] addPipe_q;

    logic [47:0]        outMem_q [OUT_DEPTH];
    logic [OPTR_W-1:0]  outWr_q, outRd_q;
    logic [CRD_W-1:0]   outCnt_q;

    logic e1Push, e2Push, e1Pop, e2Pop, issue, outPop, capture;

    function automatic logic [OPTR_W-1:0] nextOutPtr(input logic [OPTR_W-1:0] p);
        return (p == OPTR_LAST) ? '0 : p + OPTR_ONE;
    endfunction

    assign e1_ready_o  = (state_q == RUN) && (e1Cnt_q != FIFO_FULL) && (acc1_q != '0);
    assign e2_ready_o  = (state_q == RUN) && !bypass_q && (e2Cnt_q != FIFO_FULL) && (acc2_q != '0);
    assign e1Push      = e1_valid_i && e1_ready_o;
    assign e2Push      = e2_valid_i && e2_ready_o;

    assign out_valid_o = (outCnt_q != '0);
    assign out_data_o  = outMem_q[outRd_q];
    assign outPop      = out_valid_o && out_ready_i;

    // A pop in the same cycle frees a credit, which keeps full-rate streaming at the credit limit.
    assign issue = (state_q == RUN) && (e1Cnt_q != '0) && (bypass_q || (e2Cnt_q != '0))
                && ((credits_q < CRD_MAX) || outPop);
    assign e1Pop   = issue;
    assign e2Pop   = issue && !bypass_q;
    assign capture = addPipe_q[ADD_LAT-1];

    assign expand_1_o = expand1_q;
    assign expand_2_o = expand2_q;
    assign add_en_o   = addEn_q;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            bypass_q    <= 1'b0;
            remaining_q <= '0;
            acc1_q      <= '0;
            acc2_q      <= '0;
            credits_q   <= '0;
        end else begin
            state_q     <= state_d;
            bypass_q    <= bypass_d;
            remaining_q <= remaining_d;
            acc1_q      <= acc1_d;
            acc2_q      <= acc2_d;
            credits_q   <= credits_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bypass_d    = bypass_q;
        remaining_d = remaining_q;
        acc1_d      = acc1_q;
        acc2_d      = acc2_q;
        credits_d   = credits_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    remaining_d = word_count_i;
                    acc1_d      = word_count_i;
                    acc2_d      = word_count_i;
                    bypass_d    = bypass_i;
                    state_d     = (word_count_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (e1Push) acc1_d = acc1_q - CNT_ONE;
                if (e2Push) acc2_d = acc2_q - CNT_ONE;
                if (issue) begin
                    remaining_d = remaining_q - CNT_ONE;
                    if (remaining_q == CNT_ONE) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (credits_q == '0) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (issue && !outPop) begin
            credits_d = credits_q + CRD_ONE;
        end else if (!issue && outPop) begin
            credits_d = credits_q - CRD_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) e1Mem_q[i] <= '0;
            e1Wr_q  <= '0;
            e1Rd_q  <= '0;
            e1Cnt_q <= '0;
        end else begin
            if (e1Push) begin
                e1Mem_q[e1Wr_q] <= e1_data_i;
                e1Wr_q          <= e1Wr_q + PTR_ONE;
            end
            if (e1Pop) e1Rd_q <= e1Rd_q + PTR_ONE;
            case ({e1Push, e1Pop})
                2'b10:   e1Cnt_q <= e1Cnt_q + FCNT_ONE;
                2'b01:   e1Cnt_q <= e1Cnt_q - FCNT_ONE;
                default: e1Cnt_q <= e1Cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) e2Mem_q[i] <= '0;
            e2Wr_q  <= '0;
            e2Rd_q  <= '0;
            e2Cnt_q <= '0;
        end else begin
            if (e2Push) begin
                e2Mem_q[e2Wr_q] <= e2_data_i;
                e2Wr_q          <= e2Wr_q + PTR_ONE;
            end
            if (e2Pop) e2Rd_q <= e2Rd_q + PTR_ONE;
            case ({e2Push, e2Pop})
                2'b10:   e2Cnt_q <= e2Cnt_q + FCNT_ONE;
                2'b01:   e2Cnt_q <= e2Cnt_q - FCNT_ONE;
                default: e2Cnt_q <= e2Cnt_q;
            endcase
        end
    end

    // Operands hold between issues; the pipe marks which adder cycle carries a real sum.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            expand1_q <= '0;
            expand2_q <= '0;
            addEn_q   <= 1'b0;
            addPipe_q <= '0;
        end else begin
            addEn_q <= issue;
            if (issue) begin
                expand1_q <= e1Mem_q[e1Rd_q];
                expand2_q <= bypass_q ? '0 : e2Mem_q[e2Rd_q];
            end
            addPipe_q[0] <= addEn_q;
            for (int k = 1; k < ADD_LAT; k++) addPipe_q[k] <= addPipe_q[k-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < OUT_DEPTH; i++) outMem_q[i] <= '0;
            outWr_q  <= '0;
            outRd_q  <= '0;
            outCnt_q <= '0;
        end else begin
            if (capture) begin
                outMem_q[outWr_q] <= sum_i;
                outWr_q           <= nextOutPtr(outWr_q);
            end
            if (outPop) outRd_q <= nextOutPtr(outRd_q);
            case ({capture, outPop})
                2'b10:   outCnt_q <= outCnt_q + CRD_ONE;
                2'b01:   outCnt_q <= outCnt_q - CRD_ONE;
                default: outCnt_q <= outCnt_q;
            endcase
        end
    end

endmodule
